pgr_word2byte_tx: RTL and testbench

PGR_WORD2BYTE_TX -- requirements
Module: pgr_word2byte_tx

---
 rtl/pgr_word2byte_tx.sv | 93 +++++++++
 tb/tb_pgr_word2byte_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pgr_word2byte_tx.sv
// Word-to-byte serializer feeding a UART transmitter: accepts a W-bit word and emits
// data_in_len+1 bytes with registered outputs. Define PGR_W2B_MSB_FIRST_EN for MSB-first order.
module pgr_word2byte_tx #(
   parameter  int W  = 32,
   localparam int NB = ($clog2(W / 8) < 1) ? 1 : $clog2(W / 8)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          data_in_valid,
   input  logic [W-1:0]  data_in,
   input  logic [NB-1:0] data_in_len,
   output logic          data_in_ready,
   output logic [7:0]    data_out,
   output logic          data_out_valid,
   input  logic          data_out_ready,
   output logic          data_out_last,
   output logic          busy
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t        state;
   logic [W-1:0]  word_q;
   logic [NB-1:0] remaining;
   logic [NB-1:0] index;
   logic          accept;

   // Byte k of a word; an index past the last byte yields zero rather than wrapping.
   function automatic logic [7:0] pick(input logic [W-1:0] w, input logic [NB-1:0] k);
      pick = 8'h00;
      for (int i = 0; i < W / 8; i++) begin
         if (k == NB'(i)) begin
`ifdef PGR_W2B_MSB_FIRST_EN
            pick = w[W-8-8*i +: 8];
`else
            pick = w[8*i +: 8];
`endif
         end
      end
   endfunction

   assign data_in_ready = ~data_out_valid | (data_out_ready & (remaining == '0));
   assign accept        = data_in_valid & data_in_ready;
   assign busy          = data_out_valid;

   // NOTE: the word register is pure datapath, only read after a load, so it carries no reset.
   always_ff @(posedge clk) begin
      if (accept) word_q <= data_in;
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         data_out       <= 8'h00;
         data_out_valid <= 1'b0;
         data_out_last  <= 1'b0;
         remaining      <= '0;
         index          <= '0;
      end else if (accept) begin
         // Covers both a load from IDLE and the no-bubble reload after the final byte.
         state          <= SEND;
         data_out       <= pick(data_in, '0);
         data_out_valid <= 1'b1;
         data_out_last  <= (data_in_len == '0);
         remaining      <= data_in_len;
         index          <= '0;
      end else begin
         case (state)
            SEND: begin
               if (data_out_ready) begin
                  if (remaining != '0) begin
                     data_out      <= pick(word_q, index + NB'(1));
                     data_out_last <= (remaining == NB'(1));
                     remaining     <= remaining - NB'(1);
                     index         <= index + NB'(1);
                  end else begin
                     state          <= IDLE;
                     data_out_valid <= 1'b0;
                     data_out_last  <= 1'b0;
                  end
               end
            end
            default: begin
               data_out_valid <= 1'b0;
               data_out_last  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pgr_word2byte_tx.sv
// Table-driven bench for pgr_word2byte_tx (W=32) with hand sequences for reset mid-word.
module tb_pgr_word2byte_tx;

   localparam int W  = 32;
   localparam int NB = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          data_in_valid;
   logic [W-1:0]  data_in;
   logic [NB-1:0] data_in_len;
   logic          data_in_ready;
   logic [7:0]    data_out;
   logic          data_out_valid;
   logic          data_out_ready;
   logic          data_out_last;
   logic          busy;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic          in_valid;
      logic [W-1:0]  data;
      logic [NB-1:0] len;
      logic          out_ready;
      logic          exp_valid;
      logic [7:0]    exp_data;
      logic          exp_last;
      logic          exp_in_ready;
   } vec_t;

   vec_t vecs[$];

   pgr_word2byte_tx #(.W(W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .data_in_valid  (data_in_valid),
      .data_in        (data_in),
      .data_in_len    (data_in_len),
      .data_in_ready  (data_in_ready),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .data_out_ready (data_out_ready),
      .data_out_last  (data_out_last),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_tests++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic void add(input logic iv, input logic [W-1:0] d, input logic [NB-1:0] l,
                               input logic ordy, input logic ev, input logic [7:0] ed,
                               input logic el, input logic eir);
      vec_t v;
      v.in_valid = iv; v.data = d; v.len = l; v.out_ready = ordy;
      v.exp_valid = ev; v.exp_data = ed; v.exp_last = el; v.exp_in_ready = eir;
      vecs.push_back(v);
   endfunction

   // Checks registered outputs plus the combinational ready for the inputs now applied.
   task automatic check_outputs(input string tag, input logic ev, input logic [7:0] ed,
                                input logic el, input logic eir);
      check({tag, " valid"},    32'(data_out_valid), 32'(ev));
      check({tag, " data"},     32'(data_out),       32'(ed));
      check({tag, " last"},     32'(data_out_last),  32'(el));
      check({tag, " in_ready"}, 32'(data_in_ready),  32'(eir));
      check({tag, " busy"},     32'(busy),           32'(ev));
   endtask

   initial begin
      logic [7:0] rb0, rb1, ee_byte;
`ifdef PGR_W2B_MSB_FIRST_EN
      rb0 = 8'h01; rb1 = 8'h02; ee_byte = 8'h00;
      // MSB first, len=1: A1,B2
      add(1, 32'hA1B2C3D4, 1, 1, 0, 8'h00, 0, 1);
      add(0, 32'h0, 0, 1, 1, 8'hA1, 0, 0);
      add(0, 32'h0, 0, 1, 1, 8'hB2, 1, 1);
      add(0, 32'h0, 0, 1, 0, 8'hB2, 0, 1);
      // MSB first, full word
      add(1, 32'hA1B2C3D4, 3, 1, 0, 8'hB2, 0, 1);
      add(0, 32'h0, 0, 1, 1, 8'hA1, 0, 0);
      add(0, 32'h0, 0, 1, 1, 8'hB2, 0, 0);
      add(0, 32'h0, 0, 1, 1, 8'hC3, 0, 0);
      add(0, 32'h0, 0, 1, 1, 8'hD4, 1, 1);
      add(0, 32'h0, 0, 1, 0, 8'hD4, 0, 1);
`else
      rb0 = 8'h04; rb1 = 8'h03; ee_byte = 8'hEE;
      // Full word, ready held high: first row also checks post-reset state
      add(1, 32'hA1B2C3D4, 3, 1, 0, 8'h00, 0, 1);
      add(0, 32'h0, 0, 1, 1, 8'hD4, 0, 0);
      add(0, 32'h0, 0, 1, 1, 8'hC3, 0, 0);
      add(0, 32'h0, 0, 1, 1, 8'hB2, 0, 0);
      add(0, 32'h0, 0, 1, 1, 8'hA1, 1, 1);
      add(0, 32'h0, 0, 1, 0, 8'hA1, 0, 1);
      // Back-to-back words, no bubble
      add(1, 32'h11223344, 1, 1, 0, 8'hA1, 0, 1);
      add(1, 32'h55667788, 0, 1, 1, 8'h44, 0, 0);
      add(1, 32'h55667788, 0, 1, 1, 8'h33, 1, 1);
      add(0, 32'h0, 0, 1, 1, 8'h88, 1, 1);
      add(0, 32'h0, 0, 1, 0, 8'h88, 0, 1);
      // Backpressure 0,0,1,0,1
      add(1, 32'hCAFEBABE, 3, 1, 0, 8'h88, 0, 1);
      add(0, 32'h0, 0, 0, 1, 8'hBE, 0, 0);
      add(0, 32'h0, 0, 0, 1, 8'hBE, 0, 0);
      add(0, 32'h0, 0, 1, 1, 8'hBE, 0, 0);
      add(0, 32'h0, 0, 0, 1, 8'hBA, 0, 0);
      add(0, 32'h0, 0, 1, 1, 8'hBA, 0, 0);
      add(0, 32'h0, 0, 1, 1, 8'hFE, 0, 0);
      add(0, 32'h0, 0, 1, 1, 8'hCA, 1, 1);
      add(0, 32'h0, 0, 1, 0, 8'hCA, 0, 1);
      // Single byte held under backpressure while the next word waits
      add(1, 32'h0000005A, 0, 1, 0, 8'hCA, 0, 1);
      add(0, 32'h0, 0, 0, 1, 8'h5A, 1, 0);
      add(1, 32'h12345678, 3, 0, 1, 8'h5A, 1, 0);
      add(1, 32'h12345678, 3, 1, 1, 8'h5A, 1, 1);
      add(0, 32'h0, 0, 1, 1, 8'h78, 0, 0);
      add(0, 32'h0, 0, 1, 1, 8'h56, 0, 0);
      add(0, 32'h0, 0, 1, 1, 8'h34, 0, 0);
      add(0, 32'h0, 0, 1, 1, 8'h12, 1, 1);
      add(0, 32'h0, 0, 1, 0, 8'h12, 0, 1);
`endif

      rst_n = 1'b0;
      data_in_valid = 1'b0; data_in = '0; data_in_len = '0; data_out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         data_in_valid  = vecs[i].in_valid;
         data_in        = vecs[i].data;
         data_in_len    = vecs[i].len;
         data_out_ready = vecs[i].out_ready;
         #1;
         check_outputs($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                       vecs[i].exp_last, vecs[i].exp_in_ready);
      end

      // Reset asserted after the second byte of a word
      @(negedge clk);
      data_in_valid = 1'b1; data_in = 32'h01020304; data_in_len = 2'd3; data_out_ready = 1'b1;
      @(negedge clk);
      data_in_valid = 1'b0;
      #1 check_outputs("rst b0", 1, rb0, 0, 0);
      @(negedge clk);
      #1 check_outputs("rst b1", 1, rb1, 0, 0);
      #2 rst_n = 1'b0;
      #1 check_outputs("rst async", 0, 8'h00, 0, 1);
      @(negedge clk);
      rst_n = 1'b1;
      data_in_valid = 1'b1; data_in = 32'h000000EE; data_in_len = 2'd0;
      #1 check_outputs("rst release", 0, 8'h00, 0, 1);
      @(negedge clk);
      data_in_valid = 1'b0;
      #1 check_outputs("rst ee", 1, ee_byte, 1, 1);
      @(negedge clk);
      #1 check_outputs("rst idle", 0, ee_byte, 0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
